// File: rtl/branch_condition_if.sv
// Execute-stage branch request/response bundle shared by the branch unit and its driver.
interface branch_condition_if #(
    parameter int ADDR_W = 64
);
    logic              br_valid;
    logic [1:0]        br_type;
    logic [3:0]        cond;
    logic [ADDR_W-1:0] pc;
    logic [25:0]       offset;
    logic [63:0]       reg_val;
    logic              negative_in;
    logic              zero_in;
    logic              carry_in;
    logic              overflow_in;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              flush;
    logic              busy;
    logic [15:0]       taken_count;

    modport master (
        output br_valid, br_type, cond, pc, offset, reg_val,
               negative_in, zero_in, carry_in, overflow_in,
        input  taken, target, flush, busy, taken_count
    );

    modport slave (
        input  br_valid, br_type, cond, pc, offset, reg_val,
               negative_in, zero_in, carry_in, overflow_in,
        output taken, target, flush, busy, taken_count
    );
endinterface

// File: rtl/branch_condition_unit.sv
// Resolves B / B.cond / CBZ / CBNZ in execute, issues a one-cycle redirect and
// holds flush for FLUSH_CYCLES cycles while ignoring further branches.
module branch_condition_unit #(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               reset,
    branch_condition_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]        state;
    logic [3:0]        flush_cnt;
    logic              taken_q;
    logic [ADDR_W-1:0] target_q;
    logic [15:0]       count_q;

    logic              cond_ok;
    logic              take;
    logic              accept;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] next_target;

    always_comb begin
        cond_ok = 1'b1;
        case (bus.cond)
            4'h0: cond_ok = bus.zero_in;
            4'h1: cond_ok = !bus.zero_in;
            4'h2: cond_ok = bus.carry_in;
            4'h3: cond_ok = !bus.carry_in;
            4'h4: cond_ok = bus.negative_in;
            4'h5: cond_ok = !bus.negative_in;
            4'h6: cond_ok = bus.overflow_in;
            4'h7: cond_ok = !bus.overflow_in;
            4'h8: cond_ok = bus.carry_in && !bus.zero_in;
            4'h9: cond_ok = !(bus.carry_in && !bus.zero_in);
            4'hA: cond_ok = (bus.negative_in == bus.overflow_in);
            4'hB: cond_ok = (bus.negative_in != bus.overflow_in);
            4'hC: cond_ok = !bus.zero_in && (bus.negative_in == bus.overflow_in);
            4'hD: cond_ok = !(!bus.zero_in && (bus.negative_in == bus.overflow_in));
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        take = 1'b1;
        case (bus.br_type)
            2'b00: take = 1'b1;
            2'b01: take = cond_ok;
            2'b10: take = (bus.reg_val == 64'd0);
            default: take = (bus.reg_val != 64'd0);
        endcase
    end

    // Unconditional B carries a 26-bit word offset, all others 19-bit.
    always_comb begin
        if (bus.br_type == 2'b00)
            off_ext = ADDR_W'($signed(bus.offset));
        else
            off_ext = ADDR_W'($signed(bus.offset[18:0]));
        next_target = bus.pc + (off_ext << 2);
    end

    assign accept = bus.br_valid && (state == IDLE) && take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            count_q   <= 16'd0;
        end else begin
            taken_q <= accept;
            if (accept) begin
                state     <= FLUSH;
                flush_cnt <= 4'(FLUSH_CYCLES - 1);
                target_q  <= next_target;
                if (count_q != 16'hFFFF)
                    count_q <= count_q + 16'd1;
            end else if (state == FLUSH) begin
                if (flush_cnt == 4'd0)
                    state <= IDLE;
                else
                    flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    assign bus.taken       = taken_q;
    assign bus.target      = target_q;
    assign bus.flush       = (state == FLUSH);
    assign bus.busy        = (state != IDLE);
    assign bus.taken_count = count_q;
endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed plus random stimulus for branch_condition_unit against a cycle-level reference model.
module tb_branch_condition_unit;
    localparam int FC = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // reference model state
    int          m_flush_left;
    bit          m_taken;
    logic [63:0] m_target;
    int          m_count;

    branch_condition_if #(.ADDR_W(64)) bus ();

    branch_condition_unit #(.ADDR_W(64), .FLUSH_CYCLES(FC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_take(input logic [1:0] t, input logic [3:0] c,
                                    input logic [63:0] r, input bit n, input bit z,
                                    input bit cy, input bit v);
        bit gt;
        gt = !z && (n == v);
        if (t == 2'b00) return 1'b1;
        if (t == 2'b10) return r == 64'd0;
        if (t == 2'b11) return r != 64'd0;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !(cy && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return gt;
            4'hD: return !gt;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] exp_target(input logic [63:0] p, input logic [1:0] t,
                                               input logic [25:0] o);
        longint d;
        int     w;
        w = (t == 2'b00) ? 26 : 19;
        d = (t == 2'b00) ? longint'(o) : longint'(o[18:0]);
        if (d >= (longint'(1) << (w - 1))) d = d - (longint'(1) << w);
        return p + 64'(d * 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input bit v, input logic [1:0] t, input logic [3:0] c,
                          input logic [63:0] p, input logic [25:0] o, input logic [63:0] r,
                          input logic [3:0] nzcv);
        bus.br_valid    = v;
        bus.br_type     = t;
        bus.cond        = c;
        bus.pc          = p;
        bus.offset      = o;
        bus.reg_val     = r;
        bus.negative_in = nzcv[3];
        bus.zero_in     = nzcv[2];
        bus.carry_in    = nzcv[1];
        bus.overflow_in = nzcv[0];
    endtask

    // One clock: update the model from the inputs present at the edge, then compare.
    task automatic step(input string tag);
        bit accept;
        @(posedge clk);
        if (!reset) begin
            m_taken = 0; m_flush_left = 0; m_target = '0; m_count = 0;
        end else begin
            accept = bus.br_valid && (m_flush_left == 0) &&
                     exp_take(bus.br_type, bus.cond, bus.reg_val, bus.negative_in,
                              bus.zero_in, bus.carry_in, bus.overflow_in);
            m_taken = accept;
            if (accept) begin
                m_flush_left = FC;
                m_target     = exp_target(bus.pc, bus.br_type, bus.offset);
                if (m_count < 65535) m_count++;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
        end
        #1;
        chk({tag, ".taken"}, 64'(bus.taken), 64'(m_taken));
        chk({tag, ".target"}, bus.target, m_target);
        chk({tag, ".flush"}, 64'(bus.flush), 64'(m_flush_left > 0));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(m_flush_left > 0));
        chk({tag, ".count"}, 64'(bus.taken_count), 64'(m_count));
    endtask

    task automatic idle_steps(input string tag, input int n);
        set_br(0, 2'b00, 4'h0, 64'd0, 26'd0, 64'd0, 4'h0);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_flush_left = 0; m_taken = 0; m_target = '0; m_count = 0;
        reset = 1'b0;
        // br_valid asserted during reset must be ignored
        set_br(1, 2'b00, 4'h0, 64'h40, 26'd8, 64'd0, 4'h0);
        step("reset0");
        step("reset1");
        reset = 1'b1;
        idle_steps("post_reset", 1);

        // B.cond EQ with Z=1
        set_br(1, 2'b01, 4'h0, 64'h1000, 26'h00004, 64'd5, 4'b0100);
        step("eq_taken");
        chk("eq_target_abs", bus.target, 64'h1010);
        idle_steps("eq_flush", 3);

        // B.cond GE with N=1,V=0 not taken, then immediately a taken B.cond AL
        set_br(1, 2'b01, 4'hA, 64'h2000, 26'h00010, 64'd0, 4'b1000);
        step("ge_not_taken");
        set_br(1, 2'b01, 4'hE, 64'h3000, 26'h7FFFF, 64'd0, 4'b1000);
        step("al_after_nt");
        idle_steps("al_flush", 2);

        // backward B wrapping below zero
        set_br(1, 2'b00, 4'h0, 64'h0, 26'h3FFFFFF, 64'd0, 4'h0);
        step("wrap");
        chk("wrap_target_abs", bus.target, 64'hFFFF_FFFF_FFFF_FFFC);
        idle_steps("wrap_flush", 2);

        // squashing: CBZ taken, B offered in both flush cycles, then B after flush
        reset = 1'b0;
        idle_steps("rst_sq", 1);
        reset = 1'b1;
        set_br(1, 2'b10, 4'h0, 64'h5000, 26'h00020, 64'd0, 4'h0);
        step("cbz_taken");
        set_br(1, 2'b00, 4'h0, 64'h6000, 26'h00100, 64'd0, 4'h0);
        step("squash0");
        step("squash1");
        chk("squash_count_abs", 64'(bus.taken_count), 64'd1);
        step("b_after_flush");
        chk("b_after_flush_abs", 64'(bus.taken), 64'd1);
        idle_steps("b_flush", 2);

        // reset in the first flush cycle
        set_br(1, 2'b11, 4'h0, 64'h7000, 26'h00040, 64'd3, 4'h0);
        step("cbnz_taken");
        reset = 1'b0;
        idle_steps("rst_mid_flush", 1);
        chk("rst_mid_flush_abs", 64'(bus.flush), 64'd0);
        reset = 1'b1;
        idle_steps("after_rst", 1);

        // random traffic with flag/reg changes every cycle
        for (int i = 0; i < 400; i++) begin
            logic [63:0] r;
            r = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            set_br($urandom_range(0, 2) != 0, 2'($urandom), 4'($urandom),
                   {$urandom, $urandom}, 26'($urandom), r, 4'($urandom));
            reset = ($urandom_range(0, 60) != 0);
            step("rand");
        end
        reset = 1'b1;
        idle_steps("drain", 3);

        // saturation: preload 0xFFFE then three taken branches
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        m_count = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            set_br(1, 2'b00, 4'h0, 64'h100 * k, 26'h00001, 64'd0, 4'h0);
            step("sat_taken");
            idle_steps("sat_flush", 2);
        end
        chk("sat_abs", 64'(bus.taken_count), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
